// File: rtl/mem_io_sequencer.sv
// mem_io_sequencer: sequences one SRAM read/write per request over WAIT_CYCLES strobe cycles and returns read data to the MDR mux.
//   Clk, Reset (async, active-low)       : clock and reset
//   mem_req, mem_we, MAR, MDR            : request, direction, address and write data, sampled in IDLE
//   Data_from_SRAM                       : SRAM read data
//   MDR_In, MIO_EN                       : registered read data and MDR mux select (high in DONE for reads)
//   mem_done, busy                       : one-cycle completion pulse, not-IDLE indicator
//   ADDR, Data_to_SRAM, CE_N, OE_N, WE_N : SRAM address, write data and active-low strobes
//   Switches, HEX_out                    : memory-mapped I/O ports, present only when MMIO_EN is defined
// Build option: define MMIO_EN to decode IO_ADDR as the switch/hex I/O location instead of SRAM.
module mem_io_sequencer #(
    parameter int WAIT_CYCLES = 2
`ifdef MMIO_EN
    ,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
`endif
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] Data_from_SRAM,
`ifdef MMIO_EN
    input  logic [15:0] Switches,
    output logic [15:0] HEX_out,
`endif
    output logic [15:0] MDR_In,
    output logic        MIO_EN,
    output logic        mem_done,
    output logic        busy,
    output logic [15:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    output logic        CE_N,
    output logic        OE_N,
    output logic        WE_N
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      state, state_n;
    logic [15:0] addr_q, wdata_q, rd_src;
    logic        we_q, io, last;
    logic [3:0]  cnt;
    assign last = (state == ACCESS) && (cnt == 4'd0);
`ifdef MMIO_EN
    assign io     = addr_q == IO_ADDR;
    assign rd_src = io ? Switches : Data_from_SRAM;
`else
    assign io     = 1'b0;
    assign rd_src = Data_from_SRAM;
`endif
    assign ADDR         = addr_q;
    assign Data_to_SRAM = wdata_q;
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_n;
    end
    always_comb begin
        state_n  = state;
        CE_N     = 1'b1;
        OE_N     = 1'b1;
        WE_N     = 1'b1;
        mem_done = 1'b0;
        MIO_EN   = 1'b0;
        busy     = state != IDLE;
        case (state)
            IDLE:    state_n = mem_req ? ACCESS : IDLE;
            ACCESS: begin
                state_n = (cnt == 4'd0) ? DONE : ACCESS;
                // I/O accesses keep the SRAM deselected but follow the same timing
                CE_N    = io;
                OE_N    = io | we_q;
                WE_N    = io | ~we_q;
            end
            DONE: begin
                state_n  = IDLE;
                mem_done = 1'b1;
                MIO_EN   = ~we_q;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt     <= '0;
            MDR_In  <= '0;
        end else begin
            if (state == IDLE && mem_req) begin
                addr_q  <= MAR;
                wdata_q <= MDR;
                we_q    <= mem_we;
                cnt     <= 4'(WAIT_CYCLES - 1);
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (last && !we_q) MDR_In <= rd_src;
        end
    end
`ifdef MMIO_EN
    // loaded on the edge entering DONE so the new value is visible during DONE
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)                 HEX_out <= '0;
        else if (last && we_q && io) HEX_out <= wdata_q;
    end
`endif
endmodule

// File: tb/tb_mem_io_sequencer.sv
// tb_mem_io_sequencer: scoreboard bench for mem_io_sequencer with a combinational SRAM model.
module tb_mem_io_sequencer;
    localparam int W = 2;
    logic        Clk = 1'b0, Reset = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [15:0] MAR = '0, MDR = '0, Data_from_SRAM;
    logic [15:0] MDR_In, ADDR, Data_to_SRAM;
    logic        MIO_EN, mem_done, busy, CE_N, OE_N, WE_N;
`ifdef MMIO_EN
    logic [15:0] Switches = '0, HEX_out;
`endif
    int n_cmp = 0, n_err = 0;
    typedef struct {logic rd; logic [15:0] mdr;} exp_t;
    exp_t        exp_q[$];
    logic [15:0] mdr_model = '0;

    mem_io_sequencer #(.WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset), .mem_req(mem_req), .mem_we(mem_we),
        .MAR(MAR), .MDR(MDR), .Data_from_SRAM(Data_from_SRAM),
`ifdef MMIO_EN
        .Switches(Switches), .HEX_out(HEX_out),
`endif
        .MDR_In(MDR_In), .MIO_EN(MIO_EN), .mem_done(mem_done), .busy(busy),
        .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] sram(input logic [15:0] a);
        return a ^ 16'h2234;
    endfunction
    // read data is only valid while the SRAM is selected and output-enabled
    assign Data_from_SRAM = (!CE_N && !OE_N) ? sram(ADDR) : 16'hDEAD;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [15:0] rdata);
        if (!we) mdr_model = rdata;
        exp_q.push_back('{!we, mdr_model});
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        #1;
        n_cmp++;
        if ({CE_N, OE_N, WE_N, busy, mem_done, MIO_EN} !== 6'b111000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 111000", {CE_N, OE_N, WE_N, busy, mem_done, MIO_EN});
        end
        n_cmp++;
        if ({MDR_In, ADDR, Data_to_SRAM} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", {MDR_In, ADDR, Data_to_SRAM});
        end
        tick();
        tick();
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_read(input logic [15:0] a);
        exp_t e;
        MAR = a; mem_we = 1'b0; mem_req = 1'b1;
        push(1'b0, sram(a));
        tick();
        mem_req = 1'b0;
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if ({CE_N, OE_N, WE_N, busy, mem_done, ADDR} !== {5'b00110, a}) begin
                n_err++;
                $display("FAIL rd_access c%0d: got %b/%h want 00110/%h", i + 1, {CE_N, OE_N, WE_N, busy, mem_done}, ADDR, a);
            end
            tick();
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rd_done: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if ({mem_done, MIO_EN, CE_N, OE_N, MDR_In} !== {2'b11, 2'b11, e.mdr}) begin
                n_err++;
                $display("FAIL rd_done: got %b/%h want 1111/%h", {mem_done, MIO_EN, CE_N, OE_N}, MDR_In, e.mdr);
            end
        end
        tick();
        n_cmp++;
        if ({mem_done, busy, CE_N, OE_N, WE_N, MDR_In, ADDR} !== {5'b00111, mdr_model, a}) begin
            n_err++;
            $display("FAIL rd_idle: got %b/%h/%h want 00111/%h/%h", {mem_done, busy, CE_N, OE_N, WE_N}, MDR_In, ADDR, mdr_model, a);
        end
    endtask

    task automatic test_write(input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        MAR = a; MDR = d; mem_we = 1'b1; mem_req = 1'b1;
        push(1'b1, 16'h0);
        tick();
        mem_req = 1'b0; MAR = ~a; MDR = ~d; mem_we = 1'b0;
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if ({CE_N, OE_N, WE_N, Data_to_SRAM, ADDR} !== {3'b010, d, a}) begin
                n_err++;
                $display("FAIL wr_access c%0d: got %b/%h/%h want 010/%h/%h", i + 1, {CE_N, OE_N, WE_N}, Data_to_SRAM, ADDR, d, a);
            end
            tick();
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL wr_done: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if ({mem_done, MIO_EN, WE_N, MDR_In} !== {2'b10, 1'b1, e.mdr}) begin
                n_err++;
                $display("FAIL wr_done: got %b/%h want 101/%h", {mem_done, MIO_EN, WE_N}, MDR_In, e.mdr);
            end
        end
        tick();
        n_cmp++;
        if ({busy, Data_to_SRAM} !== {1'b0, d}) begin
            n_err++;
            $display("FAIL wr_idle: got %b/%h want 0/%h", busy, Data_to_SRAM, d);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        MAR = 16'h3000; mem_we = 1'b0; mem_req = 1'b1;
        push(1'b0, sram(16'h3000));
        tick();
        MAR = 16'h5555;
        push(1'b0, sram(16'h5555));
        for (int c = 1; c <= 7; c++) begin
            if (c == 3 || c == 7) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_done c%0d: scoreboard empty", c);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_done, MIO_EN, MDR_In} !== {2'b11, e.mdr}) begin
                        n_err++;
                        $display("FAIL b2b_done c%0d: got %b/%h want 11/%h", c, {mem_done, MIO_EN}, MDR_In, e.mdr);
                    end
                end
                if (c == 7) mem_req = 1'b0;
            end else if (c == 4) begin
                n_cmp++;
                if ({busy, CE_N, mem_done, ADDR} !== {3'b010, 16'h3000}) begin
                    n_err++;
                    $display("FAIL b2b_gap: got %b/%h want 010/3000", {busy, CE_N, mem_done}, ADDR);
                end
            end else begin
                n_cmp++;
                if ({CE_N, OE_N, ADDR} !== {2'b00, (c < 3) ? 16'h3000 : 16'h5555}) begin
                    n_err++;
                    $display("FAIL b2b_access c%0d: got %b/%h", c, {CE_N, OE_N}, ADDR);
                end
            end
            tick();
        end
        n_cmp++;
        if ({busy, mem_done} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_end: got %b want 00", {busy, mem_done});
        end
    endtask

    task automatic test_reset_abort;
        int dones = 0;
        MAR = 16'h1111; mem_we = 1'b0; mem_req = 1'b1;
        tick();
        mem_req = 1'b0;
        n_cmp++;
        if ({busy, CE_N} !== 2'b10) begin
            n_err++;
            $display("FAIL abort_pre: got %b want 10", {busy, CE_N});
        end
        #2 Reset = 1'b0;
        #1;
        mdr_model = '0;
        n_cmp++;
        if ({CE_N, OE_N, WE_N, busy, mem_done, MDR_In, ADDR} !== {5'b11100, 32'h0}) begin
            n_err++;
            $display("FAIL abort_async: got %b/%h/%h want 11100/0/0", {CE_N, OE_N, WE_N, busy, mem_done}, MDR_In, ADDR);
        end
        #1 Reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            dones += int'(mem_done) + int'(busy);
        end
        n_cmp++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL abort_quiet: got %0d done/busy cycles want 0", dones);
        end
    endtask

`ifdef MMIO_EN
    task automatic test_mmio;
        exp_t e;
        Switches = 16'h0077;
        MAR = 16'hFFFF; MDR = 16'h00AB; mem_we = 1'b1; mem_req = 1'b1;
        push(1'b1, 16'h0);
        tick();
        mem_req = 1'b0;
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if ({CE_N, OE_N, WE_N, busy, HEX_out} !== {4'b1111, 16'h0000}) begin
                n_err++;
                $display("FAIL io_wr_access: got %b/%h want 1111/0000", {CE_N, OE_N, WE_N, busy}, HEX_out);
            end
            tick();
        end
        n_cmp++;
        e = exp_q.pop_front();
        if ({mem_done, MIO_EN, CE_N, HEX_out, MDR_In} !== {3'b101, 16'h00AB, e.mdr}) begin
            n_err++;
            $display("FAIL io_wr_done: got %b/%h/%h want 101/00ab/%h", {mem_done, MIO_EN, CE_N}, HEX_out, MDR_In, e.mdr);
        end
        tick();
        mem_we = 1'b0; mem_req = 1'b1;
        push(1'b0, 16'h0077);
        tick();
        mem_req = 1'b0;
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if ({CE_N, OE_N, WE_N, busy} !== 4'b1111) begin
                n_err++;
                $display("FAIL io_rd_access: got %b want 1111", {CE_N, OE_N, WE_N, busy});
            end
            tick();
        end
        n_cmp++;
        e = exp_q.pop_front();
        if ({mem_done, MIO_EN, MDR_In} !== {2'b11, e.mdr}) begin
            n_err++;
            $display("FAIL io_rd_done: got %b/%h want 11/%h", {mem_done, MIO_EN}, MDR_In, e.mdr);
        end
        tick();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_read(16'h3000);
        test_write(16'h0040, 16'hBEEF);
        test_back_to_back();
        test_reset_abort();
        test_read(16'h0A5A);
`ifdef MMIO_EN
        test_mmio();
`else
        test_read(16'hFFFF);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_io_sequencer.md
Name: mem_io_sequencer

Overview:
- Memory-access stage directly upstream of the MDR unit: takes a read/write request from the control FSM, plus the address held in MAR and write data held in MDR.
- Sequences the external SRAM strobes over a fixed number of wait cycles.
- Returns read data on MDR_In, with MIO_EN selecting the memory path into the MDR mux.
- Signals completion so the control FSM can assert LD_MDR and advance.

Parameters:
- WAIT_CYCLES, 2: cycles the SRAM strobes stay asserted per access; legal range 1..15.
- IO_ADDR, 16'hFFFF: memory-mapped I/O address; used only when MMIO_EN is defined.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- mem_req  in  1  access request; sampled only in IDLE.
- mem_we  in  1  1 = write, 0 = read; sampled with mem_req.
- MAR  in  16  access address; sampled with mem_req.
- MDR  in  16  write data; sampled with mem_req.
- Data_from_SRAM  in  16  SRAM read data.
- MDR_In  out  16  registered read data to the MDR mux.
- MIO_EN  out  1  MDR mux select; 1 = memory data.
- mem_done  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state is not IDLE.
- ADDR  out  16  SRAM address.
- Data_to_SRAM  out  16  SRAM write data; tristating is done at top level.
- CE_N, OE_N, WE_N  out  1 each  active-low SRAM strobes.
- Switches  in  16  (MMIO_EN only) switch input.
- HEX_out  out  16  (MMIO_EN only) hex display register.

Behaviour:
- Reset asserted (Reset = 0):
  - Asynchronously forces state IDLE.
  - CE_N = OE_N = WE_N = 1.
  - MDR_In = 0, ADDR = 0, Data_to_SRAM = 0, HEX_out = 0.
  - mem_done = 0, MIO_EN = 0, busy = 0.
  - Any access in progress is abandoned; no mem_done is issued for it.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Strobes deasserted.
  - If mem_req = 1: latch MAR into addr_q, MDR into wdata_q, mem_we into we_q; load wait counter with WAIT_CYCLES-1; go to ACCESS.
- ACCESS:
  - ADDR = addr_q and Data_to_SRAM = wdata_q, stable for the whole state.
  - CE_N = 0. OE_N = 0 if read. WE_N = 0 if write.
  - Counter decrements each cycle. On the cycle the counter is 0:
    - a read captures Data_from_SRAM into MDR_In;
    - go to DONE.
- DONE:
  - Strobes deasserted.
  - mem_done = 1 for exactly this cycle.
  - MIO_EN = 1 in this cycle for reads only.
  - Unconditionally go to IDLE.
- Latency: request sampled at edge k. ACCESS occupies cycles k+1 .. k+WAIT_CYCLES. DONE is cycle k+WAIT_CYCLES+1.
- Throughput: with mem_req held high, back-to-back accesses repeat every WAIT_CYCLES+2 cycles.
- mem_req, MAR, MDR and mem_we are ignored outside IDLE; input changes mid-access do not affect ADDR or data.
- MDR_In holds its value until the next completed read; writes do not alter it.
- ADDR and Data_to_SRAM are registered and hold the last access values while in IDLE.

Optional Feature:
- Macro: MMIO_EN.
- Defined:
  - Switches and HEX_out ports exist.
  - An access with addr_q == IO_ADDR keeps CE_N, OE_N and WE_N high for its entire duration, with identical timing to an SRAM access.
  - A read of IO_ADDR captures Switches into MDR_In.
  - A write to IO_ADDR loads wdata_q into HEX_out at the DONE cycle.
- Undefined:
  - Switches and HEX_out ports are absent.
  - IO_ADDR is ordinary SRAM.

Test Plan:
1. Reset: drive Reset = 0 mid-simulation -> CE_N = OE_N = WE_N = 1, busy = 0, mem_done = 0, MDR_In = 0, all immediately and without waiting for a clock edge.
2. Read, WAIT_CYCLES = 2: MAR = 0x3000, Data_from_SRAM = 0x1234, mem_req pulsed at edge 0 -> CE_N = OE_N = 0 and ADDR = 0x3000 in cycles 1-2; mem_done = MIO_EN = 1 in cycle 3; MDR_In = 0x1234 from cycle 3 onward.
3. Write: MAR = 0x0040, MDR = 0xBEEF -> CE_N = WE_N = 0 and Data_to_SRAM = 0xBEEF in cycles 1-2; OE_N stays 1; mem_done in cycle 3 with MIO_EN = 0; MDR_In unchanged.
4. Stability and back-to-back: change MAR to 0x5555 during ACCESS with mem_req held high -> ADDR stays 0x3000; the second access starts at cycle 4, reads 0x5555, and completes at cycle 7.
5. Reset (Reset = 0) during ACCESS cycle 1 -> strobes go high asynchronously, no mem_done, state IDLE after release.
6. MMIO_EN defined:
   - Write 0x00AB to 0xFFFF -> HEX_out = 0x00AB at DONE; CE_N stays 1 throughout.
   - Read 0xFFFF with Switches = 0x0077 -> MDR_In = 0x0077, MIO_EN = 1 at DONE.
